seq_control: RTL and testbench
==============================

Name: seq_control

Overview:
- Self-sequencing successor to the fixed 6-state datapath controller.
- Owns its FSM and operand counter instead of taking the state as an input.
- Reduces N_OPERANDS streamed operands through bus (X), accumulator (Y), output (Z) registers and the ULA in SUM, AVG or DIFF mode.
- Drives the 4-bit register control codes tx/ty/tz/tula and uses a start/done plus valid/ready handshake.

Parameters:
- N_OPERANDS, 4: operands per operation; power of two, 2..16.
- CODE_W, 4: width of the tx/ty/tz/tula codes.
- TIMEOUT_CYCLES, 255: idle-input limit; used only with CONTROL_TIMEOUT_EN.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin operation; honoured only in IDLE.
- mode  in  2  00 SUM, 01 AVG, 10 DIFF (x0-x1-...-xN-1), 11 reserved (treated as SUM); sampled into mode_q on accepted start.
- in_valid  in  1  an operand is present on the data input.
- in_ready  out  1  controller accepts an operand this cycle.
- tx, ty, tz  out  CODE_W  register control codes: CLEAR=0, LOAD=1, HOLD=2, SHIFTR=3.
- tula  out  CODE_W  ULA op: ADD=0, SUB=1.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the result is in Z.
- error  out  1  timeout abort pulse; tied 0 without CONTROL_TIMEOUT_EN.
- state  out  3  current FSM state, for debug.

Behaviour:
- State, cnt (operands accepted, 0..N), shcnt (shifts done) and mode_q are flops.
- tx/ty/tz/tula/in_ready are combinational decode of state, cnt, shcnt, mode_q and in_valid. Control codes take effect on the same edge as the handshake.
- hs = in_valid & in_ready.
- Reset (any cycle, including mid-operation):
  - state=IDLE, cnt=0, shcnt=0, mode_q=00.
  - Outputs: tx=CLEAR, ty=HOLD, tz=HOLD, tula=ADD, in_ready=0, busy=0, done=0, error=0.
  - The partial result is abandoned and Z is never loaded.
- IDLE:
  - Outputs as in reset.
  - start -> FIRST; latch mode_q.
- FIRST:
  - in_ready=1, tz=HOLD.
  - On hs: tx=LOAD, ty=CLEAR, cnt<=1, -> STREAM.
  - Without hs: tx=HOLD, ty=HOLD.
- STREAM:
  - in_ready=1, tz=HOLD.
  - On hs: tx=LOAD and ty=LOAD together (Y absorbs the previous X while X takes the new operand), cnt++.
  - When cnt becomes N_OPERANDS -> DRAIN.
  - Without hs: tx=HOLD, ty=HOLD.
- DRAIN:
  - tx=CLEAR, ty=LOAD (absorb the last operand), in_ready=0.
  - -> SHIFT if mode_q=AVG, else -> STORE.
- SHIFT:
  - ty=SHIFTR, tx=CLEAR for exactly log2(N_OPERANDS) consecutive cycles, shcnt counting.
  - -> STORE.
- STORE: tz=LOAD, ty=HOLD, tx=CLEAR; -> DONE.
- DONE: done=1, tz=HOLD; -> IDLE (busy drops the next cycle).
- tula on each Y absorption k (0-based):
  - SUB when mode_q=DIFF and k>=1.
  - ADD otherwise.
  - ADD in all non-absorbing cycles.
- Latency: with in_valid held high, done asserts 3+N+S+1 cycles after start is sampled, where S=log2(N) for AVG and 0 otherwise. N=4 AVG: 10.
- Boundary and concurrency rules:
  - start while busy: ignored, no effect on mode_q.
  - start in the same cycle as DONE: ignored; it must be re-asserted in IDLE.
  - in_valid outside FIRST/STREAM: ignored, in_ready=0.
  - cnt never exceeds N_OPERANDS; no wrap.
  - mode changes after start have no effect.
  - Overflow of the ULA result is a datapath concern; the controller does not detect it.

Optional Feature:
- Macro: CONTROL_TIMEOUT_EN.
- When defined:
  - A watchdog counter runs in FIRST/STREAM. It clears on hs or on state entry and counts otherwise.
  - On reaching TIMEOUT_CYCLES: error=1 for one cycle with tx=CLEAR, ty=CLEAR, tz=HOLD, then -> IDLE. done is not asserted.
- When undefined: no watchdog, error tied 0, the FSM waits indefinitely for operands.

Decomposition:
- Package ctrl_pkg:
  - Register codes CLEAR/LOAD/HOLD/SHIFTR.
  - ULA codes ADD/SUB.
  - Mode encodings SUM/AVG/DIFF.
  - FSM state enum: IDLE=0, FIRST=1, STREAM=2, DRAIN=3, SHIFT=4, STORE=5, DONE=6.
- One sub-module, seq_control_decode: purely combinational mapping of (state, cnt, shcnt, mode_q, in_valid) to tx/ty/tz/tula/in_ready.
- FSM, counters and watchdog stay in the top module.

Test Plan:
- Reset, then N=4, AVG, start, in_valid held high: ty codes per cycle CLEAR, LOAD, LOAD, LOAD, LOAD, SHIFTR, SHIFTR, HOLD; tz=LOAD once; done exactly 10 cycles after start; with operands 10,20,30,40 the reference model gives Z=25.
- N=4, SUM, in_valid gaps of 2 cycles between operands: tx/ty=HOLD during gaps; no SHIFTR; Z=100 for 10,20,30,40; done once.
- N=4, DIFF with operands 100,10,20,30: tula=ADD on the first absorption, SUB on absorptions 2-4; Z=40.
- Reset asserted in STREAM after 2 operands: next cycle state=IDLE, busy=0, tz never LOAD, done never asserted; a fresh start then completes normally.
- start pulsed while busy and again during DONE: both ignored, exactly one done pulse; mode=11 behaves as SUM.
- CONTROL_TIMEOUT_EN, TIMEOUT_CYCLES=8: start, then in_valid low for 8 cycles in FIRST: error pulse 1 cycle, return to IDLE, done=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for seq_control: register/ULA control codes, operation modes
// and the FSM state enum.
package ctrl_pkg;

    localparam int REG_CLEAR  = 0;
    localparam int REG_LOAD   = 1;
    localparam int REG_HOLD   = 2;
    localparam int REG_SHIFTR = 3;

    localparam int ULA_ADD = 0;
    localparam int ULA_SUB = 1;

    // 2'b11 is reserved and falls through to SUM wherever mode_q is decoded
    localparam logic [1:0] MODE_SUM  = 2'b00;
    localparam logic [1:0] MODE_AVG  = 2'b01;
    localparam logic [1:0] MODE_DIFF = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FIRST  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        SHIFT  = 3'd4,
        STORE  = 3'd5,
        DONE   = 3'd6,
        ABORT  = 3'd7
    } state_t;

endpackage

// File: rtl/seq_control_decode.sv
// Combinational decode of the controller state into the X/Y/Z/ULA control
// codes and in_ready. in_ready depends on state only, never on in_valid.
module seq_control_decode
    import ctrl_pkg::*;
#(
    parameter int CODE_W = 4,
    parameter int CNT_W  = 3,
    parameter int SH_W   = 2,
    parameter int SHIFTS = 2
) (
    input  state_t            state,
    input  logic [CNT_W-1:0]  cnt,
    input  logic [SH_W-1:0]   shcnt,
    input  logic [1:0]        mode_q,
    input  logic              in_valid,
    output logic [CODE_W-1:0] tx,
    output logic [CODE_W-1:0] ty,
    output logic [CODE_W-1:0] tz,
    output logic [CODE_W-1:0] tula,
    output logic              in_ready
);

    always_comb begin
        tx       = CODE_W'(REG_CLEAR);
        ty       = CODE_W'(REG_HOLD);
        tz       = CODE_W'(REG_HOLD);
        tula     = CODE_W'(ULA_ADD);
        in_ready = 1'b0;
        case (state)
            FIRST: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    tx = CODE_W'(REG_LOAD);
                    ty = CODE_W'(REG_CLEAR);
                end else begin
                    tx = CODE_W'(REG_HOLD);
                end
            end
            STREAM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    tx = CODE_W'(REG_LOAD);
                    ty = CODE_W'(REG_LOAD);
                    // X holds operand cnt-1, so this is absorption k = cnt-1
                    if (mode_q == MODE_DIFF && cnt >= CNT_W'(2))
                        tula = CODE_W'(ULA_SUB);
                end else begin
                    tx = CODE_W'(REG_HOLD);
                end
            end
            DRAIN: begin
                ty = CODE_W'(REG_LOAD);
                if (mode_q == MODE_DIFF)
                    tula = CODE_W'(ULA_SUB);
            end
            SHIFT: begin
                if (shcnt < SH_W'(SHIFTS))
                    ty = CODE_W'(REG_SHIFTR);
            end
            STORE: tz = CODE_W'(REG_LOAD);
            ABORT: ty = CODE_W'(REG_CLEAR);
            default: ;
        endcase
    end

endmodule

// File: rtl/seq_control.sv
// Self-sequencing reduction controller (SUM/AVG/DIFF over N_OPERANDS operands).
// Optional watchdog abort is enabled by defining CONTROL_TIMEOUT_EN.
module seq_control
    import ctrl_pkg::*;
#(
    parameter int N_OPERANDS     = 4,
    parameter int CODE_W         = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [CODE_W-1:0] tx,
    output logic [CODE_W-1:0] ty,
    output logic [CODE_W-1:0] tz,
    output logic [CODE_W-1:0] tula,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [2:0]        state
);

    localparam int SHIFTS = $clog2(N_OPERANDS);
    localparam int CNT_W  = $clog2(N_OPERANDS + 1);
    localparam int SH_W   = $clog2(SHIFTS + 1);

    state_t           cur_state, nxt_state;
    logic [CNT_W-1:0] cnt;
    logic [SH_W-1:0]  shcnt;
    logic [1:0]       mode_q;
    logic             hs;
    logic             wd_expired;

    // Handshake: an operand transfers on every rising edge where in_valid and
    // in_ready are both high; the X/Y codes for that transfer apply on that edge.
    assign hs    = in_valid & in_ready;
    assign state = cur_state;

`ifdef CONTROL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd;
    assign wd_expired = (wd == WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign wd_expired = 1'b0;
`endif

    seq_control_decode #(
        .CODE_W (CODE_W),
        .CNT_W  (CNT_W),
        .SH_W   (SH_W),
        .SHIFTS (SHIFTS)
    ) u_decode (
        .state    (cur_state),
        .cnt      (cnt),
        .shcnt    (shcnt),
        .mode_q   (mode_q),
        .in_valid (in_valid),
        .tx       (tx),
        .ty       (ty),
        .tz       (tz),
        .tula     (tula),
        .in_ready (in_ready)
    );

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            IDLE:   if (start) nxt_state = FIRST;
            FIRST:  if (hs) nxt_state = STREAM;
                    else if (wd_expired) nxt_state = ABORT;
            STREAM: if (hs && cnt == CNT_W'(N_OPERANDS - 1)) nxt_state = DRAIN;
                    else if (!hs && wd_expired) nxt_state = ABORT;
            DRAIN:  nxt_state = (mode_q == MODE_AVG) ? SHIFT : STORE;
            SHIFT:  if (shcnt == SH_W'(SHIFTS - 1)) nxt_state = STORE;
            STORE:  nxt_state = DONE;
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cur_state <= IDLE;
            cnt       <= '0;
            shcnt     <= '0;
            mode_q    <= MODE_SUM;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
`ifdef CONTROL_TIMEOUT_EN
            wd        <= '0;
`endif
        end else begin
            cur_state <= nxt_state;
            busy      <= (nxt_state != IDLE);
            done      <= (nxt_state == DONE);
            error     <= (nxt_state == ABORT);
            if (cur_state == IDLE && start)
                mode_q <= mode;
            if (cur_state == IDLE)
                cnt <= '0;
            else if (hs)
                cnt <= cnt + CNT_W'(1);
            shcnt <= (cur_state == SHIFT) ? shcnt + SH_W'(1) : '0;
`ifdef CONTROL_TIMEOUT_EN
            // Counts idle input cycles; any transfer or state change restarts it
            if ((cur_state == FIRST || cur_state == STREAM) && !hs && nxt_state == cur_state)
                wd <= wd + WD_W'(1);
            else
                wd <= '0;
`endif
        end
    end

endmodule

// File: tb/tb_seq_control.sv
// Bench for seq_control: drives directed and random reductions through a small
// X/Y/Z datapath model and compares its Z against arithmetic expectations.
module tb_seq_control;

    localparam int N = 4;
    localparam logic [3:0] C_CLEAR  = 4'd0;
    localparam logic [3:0] C_LOAD   = 4'd1;
    localparam logic [3:0] C_HOLD   = 4'd2;
    localparam logic [3:0] C_SHIFTR = 4'd3;
    localparam logic [3:0] U_ADD    = 4'd0;
    localparam logic [3:0] U_SUB    = 4'd1;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] tx, ty, tz, tula;
    logic       busy, done, error;
    logic [2:0] state;

    logic [15:0] din = '0;
    logic [15:0] ops [N];
    logic [15:0] x_m = '0, y_m = '0, z_m = '0;
    logic [15:0] exp_q [$];
    logic [3:0]  tula_log [$];
    int done_cnt = 0, tzload_cnt = 0, shr_cnt = 0;
    int checks = 0, errors = 0;

    always #5 clock = ~clock;

    seq_control #(
        .N_OPERANDS     (N),
        .CODE_W         (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .mode     (mode),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .tx       (tx),
        .ty       (ty),
        .tz       (tz),
        .tula     (tula),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .state    (state)
    );

    // Datapath the controller steers: X bus register, Y accumulator via ULA, Z output
    always @(posedge clock) begin
        case (tx)
            C_CLEAR:  x_m <= '0;
            C_LOAD:   x_m <= din;
            C_SHIFTR: x_m <= x_m >> 1;
            default:  ;
        endcase
        case (ty)
            C_CLEAR:  y_m <= '0;
            C_LOAD:   y_m <= (tula == U_SUB) ? y_m - x_m : y_m + x_m;
            C_SHIFTR: y_m <= y_m >> 1;
            default:  ;
        endcase
        if (tz == C_LOAD) z_m <= y_m;
        if (done) done_cnt <= done_cnt + 1;
        if (tz == C_LOAD) tzload_cnt <= tzload_cnt + 1;
        if (ty == C_SHIFTR) shr_cnt <= shr_cnt + 1;
        if (ty == C_LOAD) tula_log.push_back(tula);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_z(input logic [1:0] m);
        logic [15:0] s;
        s = '0;
        for (int i = 0; i < N; i++) s = s + ops[i];
        case (m)
            2'b01:   return s >> $clog2(N);
            2'b10:   return ops[0] - (s - ops[0]);
            default: return s;
        endcase
    endfunction

    task automatic pop_and_check_z(input string tag);
        if (exp_q.size() == 0) begin
            check({tag, "_exp_q_empty"}, 1, 0);
        end else begin
            check(tag, z_m, exp_q.pop_front());
        end
    endtask

    // One full operation: gap idle cycles before each operand; poke pulses
    // start during the stream (as AVG) and again in the DONE cycle.
    task automatic run_op(input logic [1:0] m, input int gap, input bit poke, input string tag);
        int guard;
        int done0;
        done0 = done_cnt;
        exp_q.push_back(ref_z(m));
        @(negedge clock);
        start = 1'b1;
        mode = m;
        @(negedge clock);
        start = 1'b0;
        mode = 2'($urandom_range(0, 3));
        for (int i = 0; i < N; i++) begin
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                din = 16'($urandom);
                #1;
                check({tag, "_gap_tx_hold"}, tx, C_HOLD);
                check({tag, "_gap_ty_hold"}, ty, C_HOLD);
                @(negedge clock);
            end
            in_valid = 1'b1;
            din = ops[i];
            if (poke && i == 1) begin
                start = 1'b1;
                mode = 2'b01;
            end
            #1;
            check({tag, "_in_ready"}, in_ready, 1);
            @(negedge clock);
            start = 1'b0;
        end
        in_valid = 1'b0;
        guard = 0;
        while (!done && guard < 40) begin
            @(negedge clock);
            guard++;
        end
        check({tag, "_done_seen"}, done, 1);
        if (done) pop_and_check_z({tag, "_z"});
        if (poke) start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check({tag, "_idle_after_done"}, state, 0);
        check({tag, "_busy_low"}, busy, 0);
        @(negedge clock);
        check({tag, "_still_idle"}, state, 0);
        check({tag, "_one_done"}, done_cnt, done0 + 1);
    endtask

    initial begin
        logic [3:0] exp_ty [8];
        int done0, tz0, shr0, base, n;

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_state", state, 0);
        check("rst_tx", tx, C_CLEAR);
        check("rst_ty", ty, C_HOLD);
        check("rst_tz", tz, C_HOLD);
        check("rst_tula", tula, U_ADD);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        reset = 1'b0;
        @(negedge clock);

        // AVG with in_valid held high: per-cycle ty codes and latency.
        // Counting the cycle in which start is sampled as cycle 1, done lands in cycle 10.
        ops[0] = 16'd10; ops[1] = 16'd20; ops[2] = 16'd30; ops[3] = 16'd40;
        exp_ty[0] = C_CLEAR; exp_ty[1] = C_LOAD; exp_ty[2] = C_LOAD; exp_ty[3] = C_LOAD;
        exp_ty[4] = C_LOAD; exp_ty[5] = C_SHIFTR; exp_ty[6] = C_SHIFTR; exp_ty[7] = C_HOLD;
        exp_q.push_back(16'd25);
        tz0 = tzload_cnt;
        shr0 = shr_cnt;
        start = 1'b1; mode = 2'b01; in_valid = 1'b1; din = ops[0];
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            din = (i < N) ? ops[i] : 16'($urandom);
            #1;
            check("avg_ty_seq", ty, exp_ty[i]);
            check("avg_tz_seq", tz, (i == 7) ? C_LOAD : C_HOLD);
            check("avg_done_early", done, 0);
            check("avg_busy", busy, 1);
            @(negedge clock);
        end
        check("avg_done_cycle10", done, 1);
        pop_and_check_z("avg_z");
        check("avg_tz_once", tzload_cnt, tz0 + 1);
        check("avg_shiftr_2", shr_cnt, shr0 + 2);
        in_valid = 1'b0;
        @(negedge clock);
        check("avg_busy_drop", busy, 0);
        check("avg_done_pulse", done, 0);

        // SUM with 2-cycle gaps: holds during gaps, no shifting
        shr0 = shr_cnt;
        run_op(2'b00, 2, 1'b0, "sum_gap");
        check("sum_no_shiftr", shr_cnt, shr0);

        // DIFF: ADD on the first absorption, SUB afterwards
        ops[0] = 16'd100; ops[1] = 16'd10; ops[2] = 16'd20; ops[3] = 16'd30;
        base = tula_log.size();
        run_op(2'b10, 0, 1'b0, "diff");
        check("diff_absorptions", tula_log.size() - base, N);
        if (tula_log.size() - base >= N) begin
            check("diff_tula_k0", tula_log[base], U_ADD);
            for (int k = 1; k < N; k++) check("diff_tula_sub", tula_log[base + k], U_SUB);
        end

        // Reset in STREAM after 2 operands: abandon, no Z load, no done
        ops[0] = 16'd10; ops[1] = 16'd20; ops[2] = 16'd30; ops[3] = 16'd40;
        done0 = done_cnt;
        tz0 = tzload_cnt;
        @(negedge clock);
        start = 1'b1; mode = 2'b00;
        @(negedge clock);
        start = 1'b0; in_valid = 1'b1; din = ops[0];
        @(negedge clock);
        din = ops[1];
        @(negedge clock);
        in_valid = 1'b0;
        check("rst_mid_in_stream", state, 2);
        reset = 1'b1;
        @(negedge clock);
        check("rst_mid_state", state, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_in_ready", in_ready, 0);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_mid_no_tz", tzload_cnt, tz0);
        check("rst_mid_no_done", done_cnt, done0);
        run_op(2'b00, 0, 1'b0, "after_rst");

        // Reserved mode 11 behaves as SUM; start while busy and in DONE ignored
        ops[0] = 16'd7; ops[1] = 16'd9; ops[2] = 16'd100; ops[3] = 16'd4;
        run_op(2'b11, 0, 1'b1, "mode11_poke");

        // Random reductions
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++) ops[i] = 16'($urandom_range(0, 1000));
            run_op(2'($urandom_range(0, 3)), $urandom_range(0, 2), 1'($urandom_range(0, 1)), "rand");
        end

`ifdef CONTROL_TIMEOUT_EN
        // Watchdog: 8 idle cycles in FIRST abort with a one-cycle error
        done0 = done_cnt;
        @(negedge clock);
        start = 1'b1; mode = 2'b00; in_valid = 1'b0;
        @(negedge clock);
        start = 1'b0;
        n = 1;
        while (!error && n < 30) begin
            @(negedge clock);
            n++;
        end
        check("wd_cycle", n, 9);
        check("wd_error", error, 1);
        check("wd_tx_clear", tx, C_CLEAR);
        check("wd_ty_clear", ty, C_CLEAR);
        check("wd_tz_hold", tz, C_HOLD);
        check("wd_no_done", done, 0);
        @(negedge clock);
        check("wd_idle", state, 0);
        check("wd_error_pulse", error, 0);
        check("wd_done_cnt", done_cnt, done0);
`else
        n = 0;
`endif

        check("final_error_low", error, 0);
        check("final_exp_q_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
